// File: rtl/ao_obi_reg_bridge_pkg.sv
// Shared state encoding and constants for the OBI-to-register bridge.
package ao_obi_reg_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } bridge_state_e;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hBADCAB1E;
    localparam int unsigned ERR_CNT_W         = 8;

endpackage

// File: rtl/obi_pkg.sv
// OBI bus types shared by OBI masters and slaves in the always-on domain.
package obi_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

// File: rtl/reg_pkg.sv
// Register-bus types shared by the peripheral decoder and its upstream bridges.
package reg_pkg;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } reg_req_t;

    typedef struct packed {
        logic        ready;
        logic        error;
        logic [31:0] rdata;
    } reg_rsp_t;

endpackage

// File: rtl/ao_bus_timeout_cnt.sv
// Bus-stall watchdog counter: counts enabled cycles and flags the last allowed one.
module ao_bus_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (en_i) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Fires on the final stalled cycle so the owner can leave on the next edge.
    assign expired_o = en_i && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ao_obi_reg_bridge.sv
// OBI slave to register-bus bridge with a bus-timeout watchdog.
// Optional error logging is built when AO_OBI_REG_BRIDGE_ERR_LOG_EN is defined.
module ao_obi_reg_bridge
    import ao_obi_reg_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  obi_pkg::obi_req_t    slave_req_i,
    output obi_pkg::obi_resp_t   slave_resp_o,
    output reg_pkg::reg_req_t    reg_req_o,
    input  reg_pkg::reg_rsp_t    reg_rsp_i,
    output logic                 err_o,
    output logic [ERR_CNT_W-1:0] err_count_o,
    output logic [31:0]          err_addr_o
);

    bridge_state_e r_state;
    bridge_state_e w_state_next;

    logic        r_we;
    logic [3:0]  r_be;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;

    logic w_in_idle;
    logic w_in_access;
    logic w_in_resp;
    logic w_accept;
    logic w_ready;
    logic w_expired;

    assign w_in_idle   = (r_state == IDLE);
    assign w_in_access = (r_state == ACCESS);
    assign w_in_resp   = (r_state == RESP);
    assign w_accept    = w_in_idle && slave_req_i.req;
    assign w_ready     = w_in_access && reg_rsp_i.ready;

    // Watchdog; a zero timeout removes it and ACCESS waits for ready forever.
    if (TIMEOUT_CYCLES != 0) begin : g_timeout
        ao_bus_timeout_cnt #(
            .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
        ) u_timeout_cnt (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .clr_i    (!w_in_access || reg_rsp_i.ready),
            .en_i     (w_in_access && !reg_rsp_i.ready),
            .expired_o(w_expired)
        );
    end else begin : g_no_timeout
        assign w_expired = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (slave_req_i.req) begin
                    w_state_next = ACCESS;
                end
            end
            ACCESS: begin
                // Ready has priority over a coincident timeout via w_expired's enable.
                if (reg_rsp_i.ready || w_expired) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_we    <= 1'b0;
            r_be    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_we    <= slave_req_i.we;
            r_be    <= slave_req_i.be;
            r_addr  <= slave_req_i.addr;
            r_wdata <= slave_req_i.wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_ready) begin
            r_rdata <= r_we ? 32'h0 : reg_rsp_i.rdata;
            r_err   <= reg_rsp_i.error;
        end else if (w_expired) begin
            r_rdata <= ERR_RDATA;
            r_err   <= 1'b1;
        end
    end

    always_comb begin
        slave_resp_o        = '0;
        slave_resp_o.gnt    = w_accept;
        slave_resp_o.rvalid = w_in_resp;
        slave_resp_o.rdata  = w_in_resp ? r_rdata : 32'h0;

        reg_req_o       = '0;
        reg_req_o.valid = w_in_access;
        reg_req_o.write = r_we;
        reg_req_o.addr  = r_addr;
        reg_req_o.wdata = r_wdata;
        reg_req_o.wstrb = r_be;
    end

    assign err_o = w_in_resp && r_err;

`ifdef AO_OBI_REG_BRIDGE_ERR_LOG_EN
    logic [ERR_CNT_W-1:0] r_err_count;
    logic [31:0]          r_err_addr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err_count <= '0;
            r_err_addr  <= '0;
        end else if (err_o) begin
            if (r_err_count != {ERR_CNT_W{1'b1}}) begin
                r_err_count <= r_err_count + ERR_CNT_W'(1);
            end
            r_err_addr <= r_addr;
        end
    end

    assign err_count_o = r_err_count;
    assign err_addr_o  = r_err_addr;
`else
    assign err_count_o = '0;
    assign err_addr_o  = '0;
`endif

endmodule

// File: tb/tb_ao_obi_reg_bridge.sv
// Directed, table-driven bench for ao_obi_reg_bridge (watchdog set to 16 cycles).
module tb_ao_obi_reg_bridge;

    localparam int unsigned TO       = 16;
    localparam int          NEVER    = 1000;
    localparam int          MAX_CYC  = 64;
    localparam logic [31:0] ERR_DATA = 32'hBADCAB1E;

    logic               clk;
    logic               rst_ni;
    obi_pkg::obi_req_t  slave_req;
    obi_pkg::obi_resp_t slave_resp;
    reg_pkg::reg_req_t  reg_req;
    reg_pkg::reg_rsp_t  reg_rsp;
    logic               err;
    logic [7:0]         err_count;
    logic [31:0]        err_addr;

    int checks = 0;
    int errors = 0;

    int          m_err_cnt  = 0;
    logic [31:0] m_err_addr = 32'h0;

    ao_obi_reg_bridge #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .slave_req_i (slave_req),
        .slave_resp_o(slave_resp),
        .reg_req_o   (reg_req),
        .reg_rsp_i   (reg_rsp),
        .err_o       (err),
        .err_count_o (err_count),
        .err_addr_o  (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          wait_n;
        logic        rsp_err;
        logic [31:0] rsp_rdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_valid;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_log();
`ifdef AO_OBI_REG_BRIDGE_ERR_LOG_EN
        chk("err_count", {24'h0, err_count}, m_err_cnt);
        chk("err_addr", err_addr, m_err_addr);
`else
        chk("err_count_tied", {24'h0, err_count}, 32'h0);
        chk("err_addr_tied", err_addr, 32'h0);
`endif
    endtask

    // Request is held high through the access to prove no second grant before rvalid.
    task automatic run_txn(input vec_t v);
        int  vcnt;
        bit  got;
        @(negedge clk);
        slave_req.req   = 1'b1;
        slave_req.we    = v.we;
        slave_req.be    = v.be;
        slave_req.addr  = v.addr;
        slave_req.wdata = v.wdata;
        #1;
        chk("gnt_idle", {31'h0, slave_resp.gnt}, 32'h1);
        chk("valid_at_gnt", {31'h0, reg_req.valid}, 32'h0);
        vcnt = 0;
        got  = 1'b0;
        for (int k = 0; k < MAX_CYC && !got; k++) begin
            @(negedge clk);
            reg_rsp.ready = (k == v.wait_n);
            reg_rsp.error = v.rsp_err;
            reg_rsp.rdata = v.rsp_rdata;
            #1;
            chk("no_regrant", {31'h0, slave_resp.gnt}, 32'h0);
            if (reg_req.valid) begin
                vcnt++;
                chk("write", {31'h0, reg_req.write}, {31'h0, v.we});
                chk("wstrb", {28'h0, reg_req.wstrb}, {28'h0, v.be});
                chk("addr", reg_req.addr, v.addr);
                chk("wdata", reg_req.wdata, v.wdata);
            end
            if (slave_resp.rvalid) begin
                got = 1'b1;
                slave_req.req = 1'b0;
                chk("rdata", slave_resp.rdata, v.exp_rdata);
                chk("err_o", {31'h0, err}, {31'h0, v.exp_err});
                chk("valid_cycles", vcnt, v.exp_valid);
                if (v.exp_err) begin
                    if (m_err_cnt < 255) m_err_cnt++;
                    m_err_addr = v.addr;
                end
            end else begin
                chk("err_o_idle", {31'h0, err}, 32'h0);
            end
        end
        if (!got) chk("rvalid_seen", 32'h0, 32'h1);
        slave_req.req = 1'b0;
        reg_rsp       = '0;
        @(negedge clk);
        #1;
        chk("rvalid_one_cycle", {31'h0, slave_resp.rvalid}, 32'h0);
        chk_log();
    endtask

    initial begin
        vecs[0] = '{1'b0, 4'hF, 32'h2000_0010, 32'h0, 0, 1'b0,
                    32'h1234_5678, 32'h1234_5678, 1'b0, 1};
        vecs[1] = '{1'b1, 4'b0011, 32'h2000_0020, 32'hDEAD_BEEF, 3, 1'b0,
                    32'hFFFF_FFFF, 32'h0, 1'b0, 4};
        vecs[2] = '{1'b0, 4'hF, 32'h2000_0030, 32'h0, NEVER, 1'b0,
                    32'h0, ERR_DATA, 1'b1, 16};
        vecs[3] = '{1'b0, 4'hF, 32'h2000_0040, 32'h0, 0, 1'b1,
                    32'h5, 32'h5, 1'b1, 1};
        vecs[4] = '{1'b0, 4'hF, 32'h2000_0050, 32'h0, 15, 1'b0,
                    32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 16};
        vecs[5] = '{1'b1, 4'b1000, 32'h2000_0060, 32'h0BAD_F00D, 1, 1'b1,
                    32'h77, 32'h0, 1'b1, 2};

        rst_ni    = 1'b0;
        slave_req = '0;
        reg_rsp   = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_gnt", {31'h0, slave_resp.gnt}, 32'h0);
        chk("rst_rvalid", {31'h0, slave_resp.rvalid}, 32'h0);
        chk("rst_rdata", slave_resp.rdata, 32'h0);
        chk("rst_valid", {31'h0, reg_req.valid}, 32'h0);
        chk("rst_addr", reg_req.addr, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk_log();
        @(negedge clk);
        rst_ni = 1'b1;

        for (int i = 0; i < 6; i++) run_txn(vecs[i]);

        // Reset during the second ACCESS cycle aborts the access without rvalid.
        @(negedge clk);
        slave_req.req   = 1'b1;
        slave_req.we    = 1'b0;
        slave_req.addr  = 32'h2000_0070;
        #1;
        chk("rst_mid_gnt", {31'h0, slave_resp.gnt}, 32'h1);
        @(negedge clk);
        slave_req.req = 1'b0;
        #1;
        chk("rst_mid_valid1", {31'h0, reg_req.valid}, 32'h1);
        @(negedge clk);
        #1;
        chk("rst_mid_valid2", {31'h0, reg_req.valid}, 32'h1);
        rst_ni = 1'b0;
        #1;
        chk("rst_mid_valid_drop", {31'h0, reg_req.valid}, 32'h0);
        chk("rst_mid_rvalid", {31'h0, slave_resp.rvalid}, 32'h0);
        m_err_cnt  = 0;
        m_err_addr = 32'h0;
        @(negedge clk);
        rst_ni = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("rst_no_rvalid", {31'h0, slave_resp.rvalid}, 32'h0);
            chk("rst_no_valid", {31'h0, reg_req.valid}, 32'h0);
        end
        chk_log();
        run_txn(vecs[0]);

        // Many timeouts to drive the error counter into saturation.
        for (int i = 0; i < 300; i++) run_txn(vecs[2]);
`ifdef AO_OBI_REG_BRIDGE_ERR_LOG_EN
        chk("err_count_sat", {24'h0, err_count}, 32'hFF);
`else
        chk("err_count_off", {24'h0, err_count}, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
